axil_master: RTL and testbench

- AXI-Lite initiator that turns single-beat command requests from a local controller into AXI-Lite read and write transactions on the cbus port group.
- Sits between a sequencer or CPU-side requester and any AXI-Lite register block, such as the team's register-file slaves.
- One transaction in flight at a time. Each completed transaction returns exactly one response beat carrying rdata and resp.
- Synthesizable counterpart of the bench-side axil_write/axil_read tasks.

---
 rtl/axil_pkg.sv | 32 +++
 rtl/axil_master_if.sv | 55 +++++
 rtl/axil_master.sv | 205 ++++++++++++++++++++
 tb/tb_axil_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared types for the AXI-Lite initiator: response codes,
//               FSM state encoding and the default protection value.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    // AXI-Lite BRESP/RRESP encoding
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    // Initiator FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5
    } state_e;

    // Unprivileged, secure, data access
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_master_if
// Description : AXI-Lite bus bundle (AW, W, B, AR, R channels).
//               master modport : the initiator side (axil_master)
//               slave  modport : the target side (register block)
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // AW channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    // W channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    // B channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // AR channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    // R channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata,  wstrb,  wvalid,  input  wready,
        input  bresp,  bvalid,          output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata,  rresp,  rvalid,  output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata,  wstrb,  wvalid,  output wready,
        output bresp,  bvalid,          input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata,  rresp,  rvalid,  input  rready
    );

endinterface : axil_master_if
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_master
// Description : AXI-Lite initiator. Accepts one single-beat command at a
//               time, runs it on the cbus port group and returns exactly one
//               response beat (rdata, resp, write echo).
// Ports       : clk, rstn              - clock, async active-low reset
//               cmd_valid/ready        - command handshake
//               cmd_write/addr/wdata/wstrb - command payload (latched in IDLE)
//               rsp_valid/ready        - response handshake
//               rsp_rdata/resp/write   - response payload (stable in RSP)
//               cbus                   - AXI-Lite master modport
// Notes       : DATA_WIDTH must be 32 or 64.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master
    import axil_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] PROT       = PROT_DEFAULT
) (
    input  wire logic                    clk,
    input  wire logic                    rstn,
    // Command side
    input  wire logic                    cmd_valid,
    output      logic                    cmd_ready,
    input  wire logic                    cmd_write,
    input  wire logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  wire logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  wire logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // Response side
    output      logic                    rsp_valid,
    input  wire logic                    rsp_ready,
    output      logic [DATA_WIDTH-1:0]   rsp_rdata,
    output      logic [1:0]              rsp_resp,
    output      logic                    rsp_write,
    // AXI-Lite bus
    axil_master_if.master                cbus
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e                    r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_write;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [DATA_WIDTH-1:0]     r_rdata;
    resp_e                     r_resp;

    // ------------------------------------------------------------------
    // Combinational FSM outputs
    // ------------------------------------------------------------------
    state_e                    w_next_state;
    logic                      w_cmd_ready;
    logic                      w_accept;
    logic                      w_awvalid;
    logic                      w_wvalid;
    logic                      w_bready;
    logic                      w_arvalid;
    logic                      w_rready;
    logic                      w_rsp_valid;
    logic                      w_aw_done_nx;
    logic                      w_w_done_nx;
    logic                      w_b_cap;
    logic                      w_r_cap;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode. Every bus valid/ready is a pure
    // function of registered state, so an async reset clears them at once.
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_accept     = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_rsp_valid  = 1'b0;
        w_aw_done_nx = r_aw_done;
        w_w_done_nx  = r_w_done;
        w_b_cap      = 1'b0;
        w_r_cap      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = cmd_write ? WR : RD_A;
                end
            end
            WR: begin
                // AW and W are independent: each valid falls on its own
                // handshake, and both may complete in the same cycle.
                w_awvalid    = !r_aw_done;
                w_wvalid     = !r_w_done;
                w_aw_done_nx = r_aw_done | (w_awvalid & cbus.awready);
                w_w_done_nx  = r_w_done  | (w_wvalid  & cbus.wready);
                if (w_aw_done_nx && w_w_done_nx) begin
                    w_next_state = WR_B;
                end
            end
            WR_B: begin
                w_bready = 1'b1;
                if (cbus.bvalid) begin
                    w_b_cap      = 1'b1;
                    w_next_state = RSP;
                end
            end
            RD_A: begin
                w_arvalid = 1'b1;
                if (cbus.arready) begin
                    w_next_state = RD_R;
                end
            end
            RD_R: begin
                w_rready = 1'b1;
                if (cbus.rvalid) begin
                    w_r_cap      = 1'b1;
                    w_next_state = RSP;
                end
            end
            RSP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Command and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_write   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= OKAY;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_write   <= cmd_write;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                r_aw_done <= w_aw_done_nx;
                r_w_done  <= w_w_done_nx;
            end

            if (w_b_cap) begin
                r_rdata <= '0;
                r_resp  <= resp_e'(cbus.bresp);
            end else if (w_r_cap) begin
                r_rdata <= cbus.rdata;
                r_resp  <= resp_e'(cbus.rresp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive - bus payload only ever comes from the latched command
    // ------------------------------------------------------------------
    assign cbus.awaddr  = r_addr;
    assign cbus.awprot  = PROT;
    assign cbus.awvalid = w_awvalid;
    assign cbus.wdata   = r_wdata;
    assign cbus.wstrb   = r_wstrb;
    assign cbus.wvalid  = w_wvalid;
    assign cbus.bready  = w_bready;
    assign cbus.araddr  = r_addr;
    assign cbus.arprot  = PROT;
    assign cbus.arvalid = w_arvalid;
    assign cbus.rready  = w_rready;

    assign cmd_ready = w_cmd_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign rsp_write = r_write;

endmodule : axil_master
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_master
// Description : Directed bench for axil_master with a 4x32 register slave
//               whose per-channel ready/valid delays are adjustable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master;
    import axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_write;

    int n_checks = 0;
    int n_errors = 0;

    axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cbus ();

    axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .rsp_write (rsp_write),
        .cbus      (cbus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no end, expected $finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Register slave model
    // ------------------------------------------------------------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    int          aw_wait, w_wait, ar_wait, r_wait;
    logic        aw_got, w_got, r_pend;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    logic [3:0]  w_strb_l;
    logic [31:0] mem [0:3];
    int          wr_count;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_data = '0;
    logic [1:0]  ovr_resp = 2'b00;

    assign cbus.awready = cbus.awvalid && (aw_wait >= aw_delay);
    assign cbus.wready  = cbus.wvalid  && (w_wait  >= w_delay);
    assign cbus.arready = cbus.arvalid && (ar_wait >= ar_delay);

    logic        s_aw_hs, s_w_hs, s_ar_hs, s_aw_now, s_w_now;
    logic [31:0] s_aw_a, s_wd;
    logic [3:0]  s_ws;
    assign s_aw_hs  = cbus.awvalid && cbus.awready;
    assign s_w_hs   = cbus.wvalid  && cbus.wready;
    assign s_ar_hs  = cbus.arvalid && cbus.arready;
    assign s_aw_now = aw_got || s_aw_hs;
    assign s_w_now  = w_got  || s_w_hs;
    assign s_aw_a   = s_aw_hs ? cbus.awaddr : aw_addr_l;
    assign s_wd     = s_w_hs  ? cbus.wdata  : w_data_l;
    assign s_ws     = s_w_hs  ? cbus.wstrb  : w_strb_l;

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return ovr_en ? ovr_data : mem[a[3:2]];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; ar_addr_l <= '0;
            cbus.bvalid <= 1'b0; cbus.bresp <= 2'b00;
            cbus.rvalid <= 1'b0; cbus.rresp <= 2'b00; cbus.rdata <= '0;
        end else begin
            aw_wait <= (cbus.awvalid && !cbus.awready) ? aw_wait + 1 : 0;
            w_wait  <= (cbus.wvalid  && !cbus.wready)  ? w_wait  + 1 : 0;
            ar_wait <= (cbus.arvalid && !cbus.arready) ? ar_wait + 1 : 0;
            if (s_aw_hs) aw_addr_l <= cbus.awaddr;
            if (s_w_hs) begin
                w_data_l <= cbus.wdata;
                w_strb_l <= cbus.wstrb;
            end
            if (s_aw_now && s_w_now) begin
                mem[s_aw_a[3:2]] <= merge32(mem[s_aw_a[3:2]], s_wd, s_ws);
                wr_count    <= wr_count + 1;
                cbus.bvalid <= 1'b1;
                cbus.bresp  <= 2'b00;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else begin
                aw_got <= s_aw_now;
                w_got  <= s_w_now;
            end
            if (cbus.bvalid && cbus.bready) cbus.bvalid <= 1'b0;

            if (s_ar_hs) begin
                ar_addr_l <= cbus.araddr;
                r_wait    <= 0;
                if (r_delay == 0) begin
                    cbus.rvalid <= 1'b1;
                    cbus.rdata  <= rd_val(cbus.araddr);
                    cbus.rresp  <= ovr_en ? ovr_resp : 2'b00;
                end else begin
                    r_pend <= 1'b1;
                end
            end else if (r_pend) begin
                if (r_wait + 1 >= r_delay) begin
                    cbus.rvalid <= 1'b1;
                    cbus.rdata  <= rd_val(ar_addr_l);
                    cbus.rresp  <= ovr_en ? ovr_resp : 2'b00;
                    r_pend      <= 1'b0;
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
            if (cbus.rvalid && cbus.rready) cbus.rvalid <= 1'b0;
        end
    end

    initial begin
        wr_count = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the sample point right after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // lat = cycle index (accept cycle is 0) at which rsp_valid is seen.
    task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs,
                            output logic wr, output int lat);
        rsp_ready = 1'b1;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("rsp_valid_wait", rsp_valid, 1'b1);
        rd = rsp_rdata; rs = rsp_resp; wr = rsp_write;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        wr;
    int          lat, bad, cnt, ovl, wc0;
    logic        b_wr   [7];
    logic [31:0] b_addr [7];
    logic [31:0] b_data [7];
    logic [31:0] exp_rd [7];
    logic [31:0] got_rd [7];
    logic        got_wr [7];

    initial begin
        // ---- reset ----
        tick();
        chk("rst_valids", {cbus.awvalid, cbus.wvalid, cbus.arvalid, cbus.bready,
                           cbus.rready, rsp_valid}, 6'b0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
        chk("rst_addr", {cbus.awaddr, cbus.wdata, cbus.wstrb}, 68'h0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // ---- simple write, always-ready slave ----
        send_cmd(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        chk("wr_valids_c1", {cbus.awvalid, cbus.wvalid, cmd_ready}, 3'b110);
        chk("wr_payload", {cbus.awaddr, cbus.wdata, cbus.wstrb}, {32'h0, 32'hFFFF_FFFF, 4'hF});
        tick();
        chk("wr_valids_c2", {cbus.awvalid, cbus.wvalid, cbus.bready}, 3'b001);
        tick();
        chk("wr_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_rsp_done", {rsp_valid, cmd_ready}, 2'b01);
        chk("wr_count1", wr_count, 1);
        chk("wr_mem0", mem[0], 32'hFFFF_FFFF);

        // ---- read back ----
        send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
        wait_rsp(rd, rs, wr, lat);
        chk("rd0_data", {rd, rs, wr}, {32'hFFFF_FFFF, 2'b00, 1'b0});
        chk("rd0_latency", lat, 3);

        // ---- skewed AW/W ----
        aw_delay = 4;
        send_cmd(1'b1, 32'h4, 32'h1234_5678, 4'hF);
        chk("sk_c1", {cbus.awvalid, cbus.wvalid, cbus.wready, cbus.awready}, 4'b1110);
        tick();
        chk("sk_c2", {cbus.awvalid, cbus.wvalid, cbus.bready}, 3'b100);
        chk("sk_awaddr", cbus.awaddr, 32'h4);
        tick(); tick();
        chk("sk_c4", {cbus.awvalid, cbus.bready, cbus.awready}, 3'b100);
        tick();
        chk("sk_c5", {cbus.awvalid, cbus.awready, cbus.bready}, 3'b110);
        tick();
        chk("sk_c6", {cbus.awvalid, cbus.wvalid, cbus.bready}, 3'b001);
        wait_rsp(rd, rs, wr, lat);
        chk("sk_rsp", {rd, rs, wr}, {32'h0, 2'b00, 1'b1});
        chk("sk_wr_count", wr_count, 2);
        chk("sk_mem1", mem[1], 32'h1234_5678);
        aw_delay = 0;

        // ---- delayed read with SLVERR ----
        ar_delay = 3; r_delay = 5;
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; ovr_resp = 2'b10;
        send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        rsp_ready = 1'b1;
        lat = 1; bad = 0; cnt = 0;
        while (!rsp_valid && lat < 60) begin
            if (cbus.arvalid) begin
                cnt++;
                if (cbus.araddr !== 32'h8) bad++;
            end
            tick();
            lat++;
        end
        chk("dr_araddr_stable", bad, 0);
        chk("dr_arvalid_cycles", cnt, 4);
        chk("dr_latency", lat, 11);
        chk("dr_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_write}, {1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0});
        tick();
        rsp_ready = 1'b0;
        ovr_en = 1'b0; ar_delay = 0; r_delay = 0;

        // ---- response backpressure ----
        send_cmd(1'b1, 32'hC, 32'hA5A5_A5A5, 4'h3);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        cmd_write = 1'b0; cmd_addr = 32'hC; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {rsp_valid, cmd_ready, cbus.arvalid, rsp_write, rsp_resp, rsp_rdata},
                {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release", {rsp_valid, cmd_ready}, 2'b01);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept", cbus.arvalid, 1'b1);
        wait_rsp(rd, rs, wr, lat);
        chk("bp_read", {rd, rs, wr}, {32'h0000_A5A5, 2'b00, 1'b0});

        // ---- back-to-back: write 1..3, read 0..3 ----
        for (int i = 0; i < 7; i++) begin
            b_wr[i]   = (i < 3);
            b_addr[i] = (i < 3) ? 32'((i + 1) * 4) : 32'((i - 3) * 4);
            b_data[i] = (i < 3) ? 32'h1111_0001 + 32'(i) : 32'h0;
        end
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0;
        exp_rd[3] = 32'hFFFF_FFFF; exp_rd[4] = 32'h1111_0001;
        exp_rd[5] = 32'h1111_0002; exp_rd[6] = 32'h1111_0003;
        wc0 = wr_count;
        cnt = 0; bad = 0; ovl = 0;
        cmd_write = b_wr[0]; cmd_addr = b_addr[0]; cmd_wdata = b_data[0]; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && bad < 7; cyc++) begin
            logic acc;
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                got_rd[bad] = rsp_rdata;
                got_wr[bad] = rsp_write;
                bad++;
            end
            if ((cbus.awvalid || cbus.wvalid) && cbus.arvalid) ovl++;
            tick();
            if (acc) begin
                cnt++;
                if (cnt < 7) begin
                    cmd_write = b_wr[cnt]; cmd_addr = b_addr[cnt]; cmd_wdata = b_data[cnt];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("b2b_rsp_count", bad, 7);
        chk("b2b_cmd_count", cnt, 7);
        chk("b2b_overlap", ovl, 0);
        chk("b2b_wr_count", wr_count - wc0, 3);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2b_rsp%0d", i), {got_wr[i], got_rd[i]}, {b_wr[i], exp_rd[i]});
        end

        // ---- reset mid-write ----
        aw_delay = 5; w_delay = 5;
        send_cmd(1'b1, 32'h4, 32'h5555_5555, 4'hF);
        tick();
        chk("mr_pre", {cbus.awvalid, cbus.wvalid}, 2'b11);
        rstn = 1'b0;
        #1;
        chk("mr_valids", {cbus.awvalid, cbus.wvalid, cbus.arvalid, cbus.bready,
                          cbus.rready, rsp_valid}, 6'b0);
        chk("mr_idle", {cmd_ready, cbus.awaddr}, {1'b1, 32'h0});
        tick(); tick();
        rstn = 1'b1;
        aw_delay = 0; w_delay = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cbus.awvalid !== 1'b0) bad++;
        end
        chk("mr_after", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axil_master
`default_nettype wire
